// File: rtl/spi_master_param.sv
// spi_master_param: CPOL/CPHA SPI master with clock divider and one-hot chip selects; `define SPI_MASTER_LOOPBACK_EN adds a loopback input.
module spi_master_param #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 2,
  parameter int CLK_DIV = 2,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CS_W = NUM_CS > 1 ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_n,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done
);
  localparam int HW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int EW = $clog2(2 * DATA_W);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;
  state_t state, state_nxt;
  logic [HW-1:0] hcnt;
  logic [EW-1:0] ecnt;
  logic [DATA_W-1:0] tx_q, rx_q;
  logic [CS_W-1:0] cs_q;
  logic cpha_q, accept, h_last, e_last, toggle, lead, smp, drv, active, rx_bit;
  function automatic logic first_bit(input logic [DATA_W-1:0] x);
    return MSB_FIRST ? x[DATA_W-1] : x[0];
  endfunction
  function automatic logic [DATA_W-1:0] shl(input logic [DATA_W-1:0] x);
    return MSB_FIRST ? x << 1 : x >> 1;
  endfunction
  assign accept = state == IDLE && start;
  assign h_last = hcnt == HW'(CLK_DIV - 1);
  assign e_last = ecnt == EW'(2 * DATA_W - 1);
  assign toggle = state == SHIFT && h_last;
  assign lead = !ecnt[0];
  assign smp = toggle && (lead ^ cpha_q);
  assign drv = toggle && (cpha_q ? lead : !lead && !e_last);
  assign active = state == SETUP || state == SHIFT || state == HOLD;
  assign busy = state != IDLE;
  assign done = state == DONE;
  for (genvar i = 0; i < NUM_CS; i++) begin : g_cs
    assign cs_n[i] = !(active && cs_q == CS_W'(i));
  end
`ifdef SPI_MASTER_LOOPBACK_EN
  logic lb_q;
  always_ff @(posedge clk)
    if (rst) lb_q <= 1'b0;
    else if (accept) lb_q <= loopback;
  assign rx_bit = lb_q ? mosi : miso;
`else
  assign rx_bit = miso;
`endif
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? SETUP : IDLE;
      SETUP:   state_nxt = h_last ? SHIFT : SETUP;
      SHIFT:   state_nxt = h_last && e_last ? HOLD : SHIFT;
      HOLD:    state_nxt = h_last ? DONE : HOLD;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // sclk is a register that already sits at the idle level whenever no edge is pending
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      ecnt <= '0;
      tx_q <= '0;
      rx_q <= '0;
      cs_q <= '0;
      cpha_q <= 1'b0;
      sclk <= 1'b0;
      mosi <= 1'b0;
      dout <= '0;
    end else begin
      hcnt <= (state == IDLE || h_last) ? '0 : hcnt + 1'b1;
      if (toggle) begin
        sclk <= ~sclk;
        ecnt <= e_last ? '0 : ecnt + 1'b1;
      end
      if (accept) begin
        tx_q <= cpha ? din : shl(din);
        mosi <= !cpha && first_bit(din);
        cs_q <= cs_sel;
        cpha_q <= cpha;
        sclk <= cpol;
        ecnt <= '0;
        rx_q <= '0;
      end
      if (drv) begin
        mosi <= first_bit(tx_q);
        tx_q <= shl(tx_q);
      end
      if (smp) rx_q <= MSB_FIRST ? {rx_q[DATA_W-2:0], rx_bit} : {rx_bit, rx_q[DATA_W-1:1]};
      if (state == HOLD && h_last) dout <= rx_q;
    end
  end
endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: scoreboard bench with a behavioural SPI slave for spi_master_param.
module tb_spi_master_param;
  typedef struct packed {logic [7:0] d; logic [7:0] m; logic [2:0] cs; logic sc;} exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cpol = 1'b0, cpha = 1'b0, miso = 1'b0;
  logic [7:0] din = '0, dout;
  logic [1:0] cs_sel = '0;
  logic sclk, mosi, busy, done;
  logic [2:0] cs_n;
  logic start2 = 1'b0, cs_sel2 = 1'b0, cpol2 = 1'b0, cpha2 = 1'b0, miso2 = 1'b1;
  logic [7:0] din2 = '0, dout2;
  logic sclk2, mosi2, busy2, done2;
  logic [1:0] cs_n2;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic loopback = 1'b0;
`endif
  int n_chk = 0, n_fail = 0, n_done = 0, n_push = 0;
  int s_cpha = 0;
  logic [7:0] s_word = '0;
  exp_t q[$];
  logic [17:0] q2[$];

  always #5 clk = ~clk;

  spi_master_param #(.DATA_W(8), .NUM_CS(3), .CLK_DIV(2), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(loopback),
`endif
    .miso(miso), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .dout(dout), .busy(busy), .done(done));

  spi_master_param #(.DATA_W(8), .NUM_CS(2), .CLK_DIV(2), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .start(start2), .din(din2), .cs_sel(cs_sel2), .cpol(cpol2), .cpha(cpha2),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .miso(miso2), .sclk(sclk2), .mosi(mosi2), .cs_n(cs_n2), .dout(dout2), .busy(busy2), .done(done2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] d, input logic [1:0] cs, input logic pl, input logic ph,
                      input logic [7:0] sw, input logic [7:0] ed, input logic [2:0] ecs, input bit push);
    s_word = sw;
    s_cpha = int'(ph);
    din = d;
    cs_sel = cs;
    cpol = pl;
    cpha = ph;
    start = 1'b1;
    if (push) begin
      q.push_back(exp_t'{d: ed, m: d, cs: ecs, sc: pl});
      n_push++;
    end
    @(negedge clk);
    start = 1'b0;
    din = ~d;
    cs_sel = ~cs;
    cpol = ~pl;
    cpha = ~ph;
  endtask

  task automatic drain();
    int i = 0;
    while ((q.size() != 0 || q2.size() != 0 || busy || busy2) && i < 400) begin
      @(negedge clk);
      i++;
    end
    if (i >= 400) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: %0d responses still pending", q.size() + q2.size());
    end
  endtask

  // slave model plus monitors, all evaluated away from the rising edge
  initial begin
    int tog = 0, bcnt = 0, idx;
    logic bprev = 1'b0, sprev = 1'b0, sc0 = 1'b0, bprev2 = 1'b0, sprev2 = 1'b0;
    logic [2:0] cs_prev = 3'b111, cs_seen = 3'b111;
    logic [1:0] cs2_seen = 2'b11;
    logic [7:0] mcap = '0, lcap = '0;
    exp_t e;
    logic [17:0] e2;
    forever begin
      @(negedge clk);
      if (busy) begin
        if (!bprev) begin
          tog = 0;
          mcap = '0;
          bcnt = 0;
          cs_seen = 3'b111;
          sc0 = sclk;
          chk("cs_gap", 32'(cs_prev), 32'h7);
        end else if (sclk != sprev) begin
          tog++;
          if ((tog % 2) != s_cpha) mcap = {mcap[6:0], mosi};
        end
        bcnt++;
        if (!done) cs_seen = cs_seen & cs_n;
        if (done) begin
          n_done++;
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: dout=%0h with nothing pending", dout);
          end else begin
            e = q.pop_front();
            chk("dout", 32'(dout), 32'(e.d));
            chk("mosi_word", 32'(mcap), 32'(e.m));
            chk("cs_n_active", 32'(cs_seen), 32'(e.cs));
            chk("sclk_idle", 32'(sc0), 32'(e.sc));
            chk("busy_cycles", 32'(bcnt), 32'd37);
          end
        end
      end
      idx = tog < s_cpha ? 0 : (tog - s_cpha) / 2;
      if (idx > 7) idx = 7;
      miso = s_word[7-idx];
      bprev = busy;
      sprev = sclk;
      cs_prev = cs_n;
      if (busy2) begin
        if (!bprev2) begin
          lcap = '0;
          cs2_seen = cs_n2;
        end else if (sclk2 && !sprev2) lcap = {mosi2, lcap[7:1]};
        if (done2) begin
          if (q2.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done_lsb: dout=%0h with nothing pending", dout2);
          end else begin
            e2 = q2.pop_front();
            chk("lsb_dout", 32'(dout2), 32'(e2[17:10]));
            chk("lsb_mosi_word", 32'(lcap), 32'(e2[9:2]));
            chk("lsb_cs_n", 32'(cs2_seen), 32'(e2[1:0]));
          end
        end
      end
      bprev2 = busy2;
      sprev2 = sclk2;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sclk", 32'(sclk), 32'h0);
    chk("rst_mosi", 32'(mosi), 32'h0);
    chk("rst_cs_n", 32'(cs_n), 32'h7);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    xfer(8'hA5, 2'd1, 1'b0, 1'b0, 8'h3C, 8'h3C, 3'b101, 1'b1); drain();
    xfer(8'hC3, 2'd0, 1'b0, 1'b0, 8'hA5, 8'hA5, 3'b110, 1'b1); drain();
    xfer(8'hC3, 2'd0, 1'b0, 1'b1, 8'hC3, 8'hC3, 3'b110, 1'b1); drain();
    xfer(8'hC3, 2'd0, 1'b1, 1'b0, 8'hC3, 8'hC3, 3'b110, 1'b1); drain();
    xfer(8'hC3, 2'd0, 1'b1, 1'b1, 8'hC3, 8'hC3, 3'b110, 1'b1); drain();
    xfer(8'h00, 2'd2, 1'b1, 1'b1, 8'hFF, 8'hFF, 3'b011, 1'b1); drain();
    xfer(8'hFF, 2'd2, 1'b0, 1'b1, 8'h00, 8'h00, 3'b011, 1'b1); drain();
    xfer(8'h12, 2'd3, 1'b0, 1'b0, 8'h5A, 8'h5A, 3'b111, 1'b1); drain();
    // start held high: only three transfers fit before it drops
    s_word = 8'h69;
    s_cpha = 0;
    din = 8'h5C;
    cs_sel = 2'd2;
    cpol = 1'b0;
    cpha = 1'b0;
    for (int i = 0; i < 3; i++) q.push_back(exp_t'{d: 8'h69, m: 8'h5C, cs: 3'b011, sc: 1'b0});
    n_push += 3;
    start = 1'b1;
    repeat (100) @(negedge clk);
    start = 1'b0;
    drain();
    xfer(8'hB7, 2'd1, 1'b1, 1'b1, 8'h00, 8'h00, 3'b101, 1'b0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cs_n", 32'(cs_n), 32'h7);
    chk("mid_rst_sclk", 32'(sclk), 32'h0);
    chk("mid_rst_mosi", 32'(mosi), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_dout", 32'(dout), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    xfer(8'h3A, 2'd0, 1'b0, 1'b0, 8'hE1, 8'hE1, 3'b110, 1'b1); drain();
    din2 = 8'h01;
    start2 = 1'b1;
    q2.push_back({8'hFF, 8'h01, 2'b10});
    @(negedge clk);
    start2 = 1'b0;
    din2 = 8'hFE;
    drain();
`ifdef SPI_MASTER_LOOPBACK_EN
    loopback = 1'b1;
    xfer(8'h96, 2'd1, 1'b0, 1'b1, 8'h0F, 8'h96, 3'b101, 1'b1);
    loopback = 1'b0;
    drain();
`endif
    repeat (3) @(negedge clk);
    chk("done_count", 32'(n_done), 32'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
